// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control front-end: instruction field codes,
// ALU select encodings, controller state type and immediate extension helpers.
package alu_ctrl_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;

    // ALU select encodings; NOP doubles as the idle / illegal marker
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_NOP  = 4'b1111;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Sign-extend a 16-bit immediate to 32 bits
    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // Zero-extend a 16-bit immediate to 32 bits
    function automatic logic [31:0] zext16(input logic [15:0] v);
        return {16'h0000, v};
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction decoder: maps opcode/funct to an ALU select,
// picks the B operand (rt, sign- or zero-extended immediate) and flags
// write-back, branch kind and unsupported encodings.
module alu_op_decode
    import alu_ctrl_pkg::*;
(
    input  logic [5:0]  i_opcode,
    input  logic [5:0]  i_funct,
    input  logic [15:0] i_imm,
    input  logic [31:0] i_rt,
    output logic [3:0]  o_sel,
    output logic [31:0] o_b_operand,
    output logic        o_wr,
    output logic        o_is_beq,
    output logic        o_is_bne,
    output logic        o_illegal
);

    // Decode table; anything not listed falls through to the illegal default
    always_comb begin
        o_sel       = ALU_NOP;
        o_b_operand = 32'h0000_0000;
        o_wr        = 1'b0;
        o_is_beq    = 1'b0;
        o_is_bne    = 1'b0;
        o_illegal   = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                o_b_operand = i_rt;
                o_wr        = 1'b1;
                case (i_funct)
                    FN_AND:  o_sel = ALU_AND;
                    FN_OR:   o_sel = ALU_OR;
                    FN_ADD:  o_sel = ALU_ADD;
                    FN_SUB:  o_sel = ALU_SUB;
                    default: begin
                        o_sel       = ALU_NOP;
                        o_b_operand = 32'h0000_0000;
                        o_wr        = 1'b0;
                        o_illegal   = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                o_sel       = ALU_ADD;
                o_b_operand = sext16(i_imm);
                o_wr        = 1'b1;
            end
            OP_ANDI: begin
                o_sel       = ALU_AND;
                o_b_operand = zext16(i_imm);
                o_wr        = 1'b1;
            end
            OP_ORI: begin
                o_sel       = ALU_OR;
                o_b_operand = zext16(i_imm);
                o_wr        = 1'b1;
            end
            // Loads and stores only compute the address; nothing is written back here
            OP_LW, OP_SW: begin
                o_sel       = ALU_ADD;
                o_b_operand = sext16(i_imm);
            end
            // Branches compare by subtraction and read the zero flag afterwards
            OP_BEQ: begin
                o_sel       = ALU_SUB;
                o_b_operand = i_rt;
                o_is_beq    = 1'b1;
            end
            OP_BNE: begin
                o_sel       = ALU_SUB;
                o_b_operand = i_rt;
                o_is_bne    = 1'b1;
            end
            default: begin
                o_illegal   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle control front-end for an external 32-bit ALU. One instruction
// at a time: accept in IDLE, let the ALU evaluate during EXEC, hold the
// captured result in RESP until downstream takes it. Also keeps saturating
// counts of retired instructions and taken branches.
module alu_ctrl_fsm
    import alu_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_opcode,
    input  logic [5:0]       in_funct,
    input  logic [31:0]      in_rs,
    input  logic [31:0]      in_rt,
    input  logic [15:0]      in_imm,
    input  logic [31:0]      in_pc,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_sel,
    input  logic [31:0]      alu_o,
    input  logic             alu_zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_wr,
    output logic             res_br_taken,
    output logic [31:0]      res_br_target,
    output logic             res_illegal,
    output logic [CNT_W-1:0] cnt_retired,
    output logic [CNT_W-1:0] cnt_taken
);

    state_t           r_state;

    // Operand stage, loaded on the input handshake
    logic [31:0]      r_alu_a;
    logic [31:0]      r_alu_b;
    logic [3:0]       r_alu_sel;
    logic             r_wr;
    logic             r_is_beq;
    logic             r_is_bne;
    logic             r_illegal;
    logic [31:0]      r_target;

    // Result stage, loaded at the end of EXEC and frozen through RESP
    logic             r_res_valid;
    logic [31:0]      r_res_data;
    logic             r_res_wr;
    logic             r_res_taken;
    logic [31:0]      r_res_target;
    logic             r_res_illegal;

    logic [CNT_W-1:0] r_cnt_retired;
    logic [CNT_W-1:0] r_cnt_taken;

    logic [3:0]       w_sel;
    logic [31:0]      w_b_operand;
    logic             w_wr;
    logic             w_is_beq;
    logic             w_is_bne;
    logic             w_illegal;
    logic             w_accept;
    logic             w_retire;
    logic             w_taken;
    logic [31:0]      w_target;

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    alu_op_decode u_decode (
        .i_opcode    (in_opcode),
        .i_funct     (in_funct),
        .i_imm       (in_imm),
        .i_rt        (in_rt),
        .o_sel       (w_sel),
        .o_b_operand (w_b_operand),
        .o_wr        (w_wr),
        .o_is_beq    (w_is_beq),
        .o_is_bne    (w_is_bne),
        .o_illegal   (w_illegal)
    );

    assign in_ready = (r_state == IDLE);
    assign w_accept = in_valid & in_ready;
    assign w_retire = (r_state == RESP) & res_ready;

    // Branch target is computed for every instruction with its own adder,
    // so it never depends on what the ALU is doing; 32-bit wrap is intended
    assign w_target = in_pc + 32'd4 + (sext16(in_imm) << 2);

    // Branch outcome from the zero flag of the SUB issued during EXEC
    assign w_taken  = (r_is_beq & alu_zero) | (r_is_bne & ~alu_zero);

    // Control FSM with all ALU-facing and result outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_alu_a       <= 32'h0000_0000;
            r_alu_b       <= 32'h0000_0000;
            r_alu_sel     <= ALU_NOP;
            r_wr          <= 1'b0;
            r_is_beq      <= 1'b0;
            r_is_bne      <= 1'b0;
            r_illegal     <= 1'b0;
            r_target      <= 32'h0000_0000;
            r_res_valid   <= 1'b0;
            r_res_data    <= 32'h0000_0000;
            r_res_wr      <= 1'b0;
            r_res_taken   <= 1'b0;
            r_res_target  <= 32'h0000_0000;
            r_res_illegal <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_alu_a   <= in_rs;
                        r_alu_b   <= w_b_operand;
                        r_alu_sel <= w_sel;
                        r_wr      <= w_wr;
                        r_is_beq  <= w_is_beq;
                        r_is_bne  <= w_is_bne;
                        r_illegal <= w_illegal;
                        r_target  <= w_target;
                        r_state   <= EXEC;
                    end
                end
                EXEC: begin
                    // Illegal instructions leave the ALU idle; report zero rather than whatever it drives
                    r_res_data    <= r_illegal ? 32'h0000_0000 : alu_o;
                    r_res_wr      <= r_wr;
                    r_res_taken   <= w_taken;
                    r_res_target  <= r_target;
                    r_res_illegal <= r_illegal;
                    r_res_valid   <= 1'b1;
                    r_state       <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_alu_sel   <= ALU_NOP;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Performance counters advance only when a result is handed downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_retired <= '0;
            r_cnt_taken   <= '0;
        end else if (w_retire) begin
            r_cnt_retired <= sat_inc(r_cnt_retired);
            if (r_res_taken) begin
                r_cnt_taken <= sat_inc(r_cnt_taken);
            end
        end
    end

    assign alu_a         = r_alu_a;
    assign alu_b         = r_alu_b;
    assign alu_sel       = r_alu_sel;
    assign res_valid     = r_res_valid;
    assign res_data      = r_res_data;
    assign res_wr        = r_res_wr;
    assign res_br_taken  = r_res_taken;
    assign res_br_target = r_res_target;
    assign res_illegal   = r_res_illegal;
    assign cnt_retired   = r_cnt_retired;
    assign cnt_taken     = r_cnt_taken;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Bench for alu_ctrl_fsm: directed instructions with literal expectations,
// then randomized traffic checked every cycle against a transaction model.
module tb_alu_ctrl_fsm;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [5:0]       in_opcode = 6'h00;
    logic [5:0]       in_funct = 6'h00;
    logic [31:0]      in_rs = 32'h0;
    logic [31:0]      in_rt = 32'h0;
    logic [15:0]      in_imm = 16'h0;
    logic [31:0]      in_pc = 32'h0;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [3:0]       alu_sel;
    logic [31:0]      alu_o;
    logic             alu_zero;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [31:0]      res_data;
    logic             res_wr;
    logic             res_br_taken;
    logic [31:0]      res_br_target;
    logic             res_illegal;
    logic [CNT_W-1:0] cnt_retired;
    logic [CNT_W-1:0] cnt_taken;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_ctrl_fsm #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opcode     (in_opcode),
        .in_funct      (in_funct),
        .in_rs         (in_rs),
        .in_rt         (in_rt),
        .in_imm        (in_imm),
        .in_pc         (in_pc),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_sel       (alu_sel),
        .alu_o         (alu_o),
        .alu_zero      (alu_zero),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_wr        (res_wr),
        .res_br_taken  (res_br_taken),
        .res_br_target (res_br_target),
        .res_illegal   (res_illegal),
        .cnt_retired   (cnt_retired),
        .cnt_taken     (cnt_taken)
    );

    // The parent's ALU; an idle/illegal select drives a recognisable junk value
    always_comb begin
        case (alu_sel)
            4'b0000: alu_o = alu_a & alu_b;
            4'b0001: alu_o = alu_a | alu_b;
            4'b0010: alu_o = alu_a + alu_b;
            4'b0011: alu_o = alu_a - alu_b;
            default: alu_o = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_o == 32'd0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    typedef struct packed {
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic [31:0] target;
        logic        wr;
        logic        taken;
        logic        illegal;
    } txn_t;

    // What one instruction must produce, straight from the instruction-set rules
    function automatic txn_t ref_model(input logic [5:0] op, input logic [5:0] fn,
                                       input logic [31:0] rs, input logic [31:0] rt,
                                       input logic [15:0] imm, input logic [31:0] pc);
        txn_t t;
        logic [31:0] se;
        logic [31:0] ze;
        se = {{16{imm[15]}}, imm};
        ze = {16'h0, imm};
        t.a = rs; t.b = rt; t.sel = 4'hF; t.wr = 1'b0; t.taken = 1'b0; t.illegal = 1'b0;
        t.target = pc + 32'd4 + se * 32'd4;
        case (op)
            6'h00: case (fn)
                       6'h24: begin t.sel = 4'h0; t.wr = 1'b1; end
                       6'h25: begin t.sel = 4'h1; t.wr = 1'b1; end
                       6'h20: begin t.sel = 4'h2; t.wr = 1'b1; end
                       6'h22: begin t.sel = 4'h3; t.wr = 1'b1; end
                       default: t.illegal = 1'b1;
                   endcase
            6'h08: begin t.sel = 4'h2; t.b = se; t.wr = 1'b1; end
            6'h0C: begin t.sel = 4'h0; t.b = ze; t.wr = 1'b1; end
            6'h0D: begin t.sel = 4'h1; t.b = ze; t.wr = 1'b1; end
            6'h23, 6'h2B: begin t.sel = 4'h2; t.b = se; end
            6'h04: begin t.sel = 4'h3; t.taken = (rs == rt); end
            6'h05: begin t.sel = 4'h3; t.taken = (rs != rt); end
            default: t.illegal = 1'b1;
        endcase
        case (t.sel)
            4'h0:    t.data = t.a & t.b;
            4'h1:    t.data = t.a | t.b;
            4'h2:    t.data = t.a + t.b;
            4'h3:    t.data = t.a - t.b;
            default: t.data = 32'h0;
        endcase
        return t;
    endfunction

    // Model state: one instruction in flight, plus cycles elapsed since it was taken
    bit   m_busy = 1'b0;
    int   m_age = 0;
    txn_t m_cur;
    int   m_ret = 0;
    int   m_tak = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_ret  = 0;
            m_tak  = 0;
        end else if (m_busy) begin
            if (m_age == 0) begin
                m_age = 1;
            end else if (res_ready) begin
                m_busy = 1'b0;
                if (m_ret < CNT_MAX) m_ret++;
                if (m_cur.taken && m_tak < CNT_MAX) m_tak++;
            end
        end else if (in_valid) begin
            m_busy = 1'b1;
            m_age  = 0;
            m_cur  = ref_model(in_opcode, in_funct, in_rs, in_rt, in_imm, in_pc);
        end
    end

    // Every-cycle comparison on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", 64'(in_ready), 64'(1));
            chk("rst_res_valid", 64'(res_valid), 64'(0));
            chk("rst_alu_sel", 64'(alu_sel), 64'(4'hF));
            chk("rst_cnt_retired", 64'(cnt_retired), 64'(0));
            chk("rst_cnt_taken", 64'(cnt_taken), 64'(0));
        end else begin
            chk("in_ready", 64'(in_ready), 64'(!m_busy));
            chk("res_valid", 64'(res_valid), 64'(m_busy && m_age == 1));
            chk("alu_sel", 64'(alu_sel), 64'(m_busy ? m_cur.sel : 4'hF));
            chk("cnt_retired", 64'(cnt_retired), 64'(m_ret));
            chk("cnt_taken", 64'(cnt_taken), 64'(m_tak));
            if (m_busy && m_age == 0 && !m_cur.illegal) begin
                chk("alu_a", 64'(alu_a), 64'(m_cur.a));
                chk("alu_b", 64'(alu_b), 64'(m_cur.b));
            end
            if (m_busy && m_age == 1) begin
                chk("res_data", 64'(res_data), 64'(m_cur.data));
                chk("res_wr", 64'(res_wr), 64'(m_cur.wr));
                chk("res_illegal", 64'(res_illegal), 64'(m_cur.illegal));
                chk("res_br_taken", 64'(res_br_taken), 64'(m_cur.taken));
                if (m_cur.taken) chk("res_br_target", 64'(res_br_target), 64'(m_cur.target));
            end
        end
    end

    // ---------------- directed instructions ----------------
    task automatic run_dir(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input logic [31:0] rs, input logic [31:0] rt,
                           input logic [15:0] imm, input logic [31:0] pc,
                           input logic [3:0] e_sel, input logic [31:0] e_data,
                           input logic e_wr, input logic e_tk, input logic [31:0] e_tgt,
                           input logic e_ill);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk({nm, "_idle_wait"}, 64'(in_ready), 64'(1));
        in_opcode = op; in_funct = fn; in_rs = rs; in_rt = rt; in_imm = imm; in_pc = pc;
        in_valid = 1'b1; res_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({nm, "_sel"}, 64'(alu_sel), 64'(e_sel));
        chk({nm, "_early_valid"}, 64'(res_valid), 64'(0));
        @(posedge clk); #1;
        chk({nm, "_valid"}, 64'(res_valid), 64'(1));
        chk({nm, "_data"}, 64'(res_data), 64'(e_data));
        chk({nm, "_wr"}, 64'(res_wr), 64'(e_wr));
        chk({nm, "_taken"}, 64'(res_br_taken), 64'(e_tk));
        chk({nm, "_illegal"}, 64'(res_illegal), 64'(e_ill));
        if (e_tk) chk({nm, "_target"}, 64'(res_br_target), 64'(e_tgt));
        @(posedge clk); #1;
        chk({nm, "_back_idle"}, 64'(in_ready), 64'(1));
        chk({nm, "_sel_idle"}, 64'(alu_sel), 64'(4'hF));
    endtask

    function automatic logic [5:0] pick_op(input int k);
        case (k)
            0, 1, 2: return 6'h00;
            3:       return 6'h08;
            4:       return 6'h0C;
            5:       return 6'h0D;
            6:       return 6'h23;
            7:       return 6'h2B;
            8:       return 6'h04;
            9:       return 6'h05;
            default: return 6'($urandom);
        endcase
    endfunction

    function automatic logic [5:0] pick_fn(input int k);
        case (k)
            0:       return 6'h24;
            1:       return 6'h25;
            2:       return 6'h20;
            3:       return 6'h22;
            default: return 6'($urandom);
        endcase
    endfunction

    initial begin
        int rst_hold;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));
        chk("post_rst_sel", 64'(alu_sel), 64'(4'hF));
        chk("post_rst_cnt", 64'(cnt_retired), 64'(0));

        // Backpressure: result held while downstream stalls, extra beat ignored
        in_opcode = 6'h0D; in_funct = 6'h00; in_rs = 32'h0F0F_0000; in_rt = 32'h0;
        in_imm = 16'h00FF; in_pc = 32'h0; in_valid = 1'b1; res_ready = 1'b0;
        @(posedge clk); #1;
        in_opcode = 6'h00; in_funct = 6'h20; in_rs = 32'd1; in_rt = 32'd1;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 64'(res_valid), 64'(1));
            chk("stall_in_ready", 64'(in_ready), 64'(0));
            chk("stall_data", 64'(res_data), 64'(32'h0F0F_00FF));
            chk("stall_sel", 64'(alu_sel), 64'(4'h1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0; res_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_cnt_retired", 64'(cnt_retired), 64'(1));
        chk("stall_in_ready_back", 64'(in_ready), 64'(1));

        run_dir("add",   6'h00, 6'h20, 32'd5, 32'd7, 16'h0000, 32'h0,
                4'h2, 32'd12, 1'b1, 1'b0, 32'h0, 1'b0);
        run_dir("beq",   6'h04, 6'h00, 32'h1234, 32'h1234, 16'hFFFF, 32'h100,
                4'h3, 32'h0, 1'b0, 1'b1, 32'h100, 1'b0);
        run_dir("bne",   6'h05, 6'h00, 32'h1234, 32'h1234, 16'hFFFF, 32'h100,
                4'h3, 32'h0, 1'b0, 1'b0, 32'h100, 1'b0);
        run_dir("andi",  6'h0C, 6'h00, 32'hFFFF_FFFF, 32'h0, 16'h8001, 32'h0,
                4'h0, 32'h0000_8001, 1'b1, 1'b0, 32'h0, 1'b0);
        run_dir("addi",  6'h08, 6'h00, 32'h0, 32'h0, 16'h8000, 32'h0,
                4'h2, 32'hFFFF_8000, 1'b1, 1'b0, 32'h0, 1'b0);
        run_dir("illeg", 6'h3F, 6'h00, 32'h55, 32'h66, 16'h1234, 32'h0,
                4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        // Seven instructions retired into a 2-bit counter: stuck at 3
        chk("sat_cnt_retired", 64'(cnt_retired), 64'(3));
        chk("sat_cnt_taken", 64'(cnt_taken), 64'(1));

        // Reset while the instruction sits in EXEC: dropped, no result pulse
        in_opcode = 6'h00; in_funct = 6'h22; in_rs = 32'd10; in_rt = 32'd3;
        in_valid = 1'b1; res_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(res_valid), 64'(0));
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        chk("midrst_cnt_retired", 64'(cnt_retired), 64'(0));
        chk("midrst_cnt_taken", 64'(cnt_taken), 64'(0));
        @(posedge clk); #1;
        chk("midrst_no_pulse", 64'(res_valid), 64'(0));

        // Randomized traffic with occasional resets
        rst_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (rst_hold > 0) begin
                rst_n = 1'b0;
                rst_hold--;
            end else begin
                rst_n = 1'b1;
                if ($urandom_range(0, 299) == 0) begin
                    rst_n = 1'b0;
                    rst_hold = 1;
                end
            end
            in_valid  = ($urandom_range(0, 2) != 0);
            in_opcode = pick_op(int'($urandom_range(0, 10)));
            in_funct  = pick_fn(int'($urandom_range(0, 4)));
            in_rs     = $urandom;
            in_rt     = ($urandom_range(0, 3) == 0) ? in_rs : $urandom;
            in_imm    = 16'($urandom);
            in_pc     = $urandom;
            res_ready = ($urandom_range(0, 3) != 0);
        end
        rst_n = 1'b1; in_valid = 1'b0; res_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
